// File: rtl/txn_control_n.sv
// txn_control_n: control FSM for a wallet-transfer datapath.
// Boots the datapath (random table, wallet memory), clears it, then walks the
// user through entering payer, payee, amount and key with the load button,
// validates each entry, and runs one transaction with cancel and timeout.
// Ports:
//   clock, resetn            clock and synchronous active-low reset
//   load_signal              level load button; its rising edge is `press`
//   start_signal, cancel     start / abort requests
//   data_in                  switch value captured on `press`
//   done_table_init, finished_init, finished_transaction  datapath status
//   global_reset .. reset_others  Moore control strobes, registered
//   src_id, dst_id, amount, key   latched transaction fields
//   err_pulse, timeout_pulse      one-cycle event pulses
//   state_o                  current state code
module txn_control_n #(
    parameter int unsigned NUM_PLAYERS    = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned CLEAR_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    localparam int unsigned PID_W = (NUM_PLAYERS <= 2) ? 1 : $clog2(NUM_PLAYERS)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_signal,
    input  logic              start_signal,
    input  logic              cancel,
    input  logic [DATA_W-1:0] data_in,
    input  logic              done_table_init,
    input  logic              finished_init,
    input  logic              finished_transaction,
    output logic              global_reset,
    output logic              random_init,
    output logic              init_memory,
    output logic              load_memory,
    output logic              start_transaction,
    output logic              reset_others,
    output logic [PID_W-1:0]  src_id,
    output logic [PID_W-1:0]  dst_id,
    output logic [DATA_W-1:0] amount,
    output logic [DATA_W-1:0] key,
    output logic              err_pulse,
    output logic              timeout_pulse,
    output logic [3:0]        state_o
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > TIMEOUT_CYCLES) ? CLEAR_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_STARTUP    = 4'd0,
        S_INIT_TABLE = 4'd1,
        S_INIT_MEM   = 4'd2,
        S_CLEAR      = 4'd3,
        S_IDLE       = 4'd4,
        S_LD_SRC     = 4'd5,
        S_LD_DST     = 4'd6,
        S_LD_AMT     = 4'd7,
        S_LD_KEY     = 4'd8,
        S_ARMED      = 4'd9,
        S_TXN        = 4'd10
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               load_signal_q;
    logic               press;
    logic [CNT_W-1:0]   cnt;
    logic [PID_W-1:0]   entry_id;
    logic               err_c;
    logic               tmo_c;
    logic               ld_src_c;
    logic               ld_dst_c;
    logic               ld_amt_c;
    logic               ld_key_c;

    assign entry_id = data_in[PID_W-1:0];
    assign state_o  = state;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= S_STARTUP;
        else         state <= next_state;
    end

    // Next-state, entry validation and latch enables.
    always_comb begin
        next_state = state;
        err_c      = 1'b0;
        tmo_c      = 1'b0;
        ld_src_c   = 1'b0;
        ld_dst_c   = 1'b0;
        ld_amt_c   = 1'b0;
        ld_key_c   = 1'b0;
        case (state)
            S_STARTUP:    if (press) next_state = S_INIT_TABLE;
            S_INIT_TABLE: if (done_table_init) next_state = S_INIT_MEM;
            S_INIT_MEM:   if (finished_init) next_state = S_CLEAR;
            S_CLEAR:      if (cnt == CNT_W'(CLEAR_CYCLES - 1)) next_state = S_IDLE;
            S_IDLE:       if (press) next_state = S_LD_SRC;
            S_LD_SRC: if (press) begin
                if (32'(entry_id) >= NUM_PLAYERS) begin
                    err_c = 1'b1;
                    next_state = S_CLEAR;
                end else begin
                    ld_src_c = 1'b1;
                    next_state = S_LD_DST;
                end
            end
            S_LD_DST: if (press) begin
                if ((32'(entry_id) >= NUM_PLAYERS) || (entry_id == src_id)) begin
                    err_c = 1'b1;
                    next_state = S_CLEAR;
                end else begin
                    ld_dst_c = 1'b1;
                    next_state = S_LD_AMT;
                end
            end
            S_LD_AMT: if (press) begin
                if (data_in == '0) begin
                    err_c = 1'b1;
                    next_state = S_CLEAR;
                end else begin
                    ld_amt_c = 1'b1;
                    next_state = S_LD_KEY;
                end
            end
            S_LD_KEY: if (press) begin
                ld_key_c = 1'b1;
                next_state = S_ARMED;
            end
            S_ARMED: if (start_signal) next_state = S_TXN;
            S_TXN: begin
                if (finished_transaction) begin
                    next_state = S_CLEAR;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_c = 1'b1;
                    next_state = S_CLEAR;
                end
            end
            default: next_state = S_STARTUP;
        endcase
        // Abort wins over everything, including the pulses it would suppress.
        if (cancel && (state >= S_LD_SRC) && (state <= S_TXN)) begin
            next_state = S_CLEAR;
            err_c      = 1'b0;
            tmo_c      = 1'b0;
            ld_src_c   = 1'b0;
            ld_dst_c   = 1'b0;
            ld_amt_c   = 1'b0;
            ld_key_c   = 1'b0;
        end
    end

    // Datapath registers; Moore strobes are decoded from next_state so they
    // line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            load_signal_q     <= 1'b0;
            press             <= 1'b0;
            cnt               <= '0;
            src_id            <= '0;
            dst_id            <= '0;
            amount            <= '0;
            key               <= '0;
            err_pulse         <= 1'b0;
            timeout_pulse     <= 1'b0;
            global_reset      <= 1'b0;
            random_init       <= 1'b0;
            init_memory       <= 1'b0;
            load_memory       <= 1'b0;
            start_transaction <= 1'b0;
            reset_others      <= 1'b1;
        end else begin
            load_signal_q <= load_signal;
            press         <= load_signal & ~load_signal_q;
            err_pulse     <= err_c;
            timeout_pulse <= tmo_c;
            // Dwell counter restarts on every state change.
            cnt <= (next_state != state) ? '0 : cnt + CNT_W'(1);
            if (next_state == S_CLEAR) begin
                src_id <= '0;
                dst_id <= '0;
                amount <= '0;
                key    <= '0;
            end else begin
                if (ld_src_c) src_id <= entry_id;
                if (ld_dst_c) dst_id <= entry_id;
                if (ld_amt_c) amount <= data_in;
                if (ld_key_c) key    <= data_in;
            end
            global_reset      <= (next_state != S_STARTUP);
            random_init       <= (next_state == S_INIT_TABLE);
            init_memory       <= (next_state == S_INIT_MEM);
            load_memory       <= (next_state == S_IDLE);
            start_transaction <= (next_state == S_TXN);
            reset_others      <= (next_state != S_CLEAR);
        end
    end

endmodule

// File: tb/tb_txn_control_n.sv
// tb_txn_control_n: directed scenarios followed by random stimulus, driving
// two instances (4 and 3 wallets, short timeout) and comparing every output
// each cycle against a behavioural model of the control rules.
module tb_txn_control_n;

    localparam int unsigned TO  = 16;
    localparam int unsigned CLR = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       load_signal = 1'b0;
    logic       start_signal = 1'b0;
    logic       cancel = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       done_table_init = 1'b0;
    logic       finished_init = 1'b0;
    logic       finished_transaction = 1'b0;

    logic       a_grst, a_rinit, a_imem, a_lmem, a_stx, a_roth, a_err, a_tmo;
    logic [1:0] a_src, a_dst;
    logic [7:0] a_amt, a_key;
    logic [3:0] a_state;
    logic       b_grst, b_rinit, b_imem, b_lmem, b_stx, b_roth, b_err, b_tmo;
    logic [1:0] b_src, b_dst;
    logic [7:0] b_amt, b_key;
    logic [3:0] b_state;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    txn_control_n #(.NUM_PLAYERS(4), .DATA_W(8), .CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)) dut_a (
        .clock(clock), .resetn(resetn), .load_signal(load_signal), .start_signal(start_signal),
        .cancel(cancel), .data_in(data_in), .done_table_init(done_table_init),
        .finished_init(finished_init), .finished_transaction(finished_transaction),
        .global_reset(a_grst), .random_init(a_rinit), .init_memory(a_imem), .load_memory(a_lmem),
        .start_transaction(a_stx), .reset_others(a_roth), .src_id(a_src), .dst_id(a_dst),
        .amount(a_amt), .key(a_key), .err_pulse(a_err), .timeout_pulse(a_tmo), .state_o(a_state));

    txn_control_n #(.NUM_PLAYERS(3), .DATA_W(8), .CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)) dut_b (
        .clock(clock), .resetn(resetn), .load_signal(load_signal), .start_signal(start_signal),
        .cancel(cancel), .data_in(data_in), .done_table_init(done_table_init),
        .finished_init(finished_init), .finished_transaction(finished_transaction),
        .global_reset(b_grst), .random_init(b_rinit), .init_memory(b_imem), .load_memory(b_lmem),
        .start_transaction(b_stx), .reset_others(b_roth), .src_id(b_src), .dst_id(b_dst),
        .amount(b_amt), .key(b_key), .err_pulse(b_err), .timeout_pulse(b_tmo), .state_o(b_state));

    // Model of one controller: phase number, cycles spent in it, entered fields.
    typedef struct {
        int st;
        int dwell;
        int src;
        int dst;
        int amt;
        int key;
        bit btn_prev;
        bit pressed;
        bit err;
        bit tmo;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(input mdl_t m, input int np);
        mdl_t r;
        int   nxt;
        int   v;
        r = m;
        r.err = 0;
        r.tmo = 0;
        if (!resetn) begin
            r = '{default: 0};
            return r;
        end
        r.btn_prev = load_signal;
        r.pressed  = load_signal && !m.btn_prev;
        v   = int'(data_in);
        nxt = m.st;
        if (m.st == 0 && m.pressed) nxt = 1;
        else if (m.st == 1 && done_table_init) nxt = 2;
        else if (m.st == 2 && finished_init) nxt = 3;
        else if (m.st == 3 && m.dwell + 1 >= CLR) nxt = 4;
        else if (m.st == 4 && m.pressed) nxt = 5;
        else if (m.st == 5 && m.pressed) begin
            if (v % 4 >= np) begin r.err = 1; nxt = 3; end
            else begin r.src = v % 4; nxt = 6; end
        end else if (m.st == 6 && m.pressed) begin
            if (v % 4 >= np || v % 4 == m.src) begin r.err = 1; nxt = 3; end
            else begin r.dst = v % 4; nxt = 7; end
        end else if (m.st == 7 && m.pressed) begin
            if (v == 0) begin r.err = 1; nxt = 3; end
            else begin r.amt = v; nxt = 8; end
        end else if (m.st == 8 && m.pressed) begin
            r.key = v; nxt = 9;
        end else if (m.st == 9 && start_signal) nxt = 10;
        else if (m.st == 10) begin
            if (finished_transaction) nxt = 3;
            else if (m.dwell + 1 >= TO) begin r.tmo = 1; nxt = 3; end
        end
        if (cancel && m.st >= 5 && m.st <= 10) begin
            r = m;
            r.btn_prev = load_signal;
            r.pressed  = load_signal && !m.btn_prev;
            r.err = 0;
            r.tmo = 0;
            nxt = 3;
        end
        if (nxt == 3) begin
            r.src = 0; r.dst = 0; r.amt = 0; r.key = 0;
        end
        r.dwell = (nxt == m.st) ? m.dwell + 1 : 0;
        r.st = nxt;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.state", 32'(a_state), 32'(ma.st));
        chk("a.global_reset", 32'(a_grst), 32'(ma.st != 0));
        chk("a.random_init", 32'(a_rinit), 32'(ma.st == 1));
        chk("a.init_memory", 32'(a_imem), 32'(ma.st == 2));
        chk("a.load_memory", 32'(a_lmem), 32'(ma.st == 4));
        chk("a.start_transaction", 32'(a_stx), 32'(ma.st == 10));
        chk("a.reset_others", 32'(a_roth), 32'(ma.st != 3));
        chk("a.src_id", 32'(a_src), 32'(ma.src));
        chk("a.dst_id", 32'(a_dst), 32'(ma.dst));
        chk("a.amount", 32'(a_amt), 32'(ma.amt));
        chk("a.key", 32'(a_key), 32'(ma.key));
        chk("a.err_pulse", 32'(a_err), 32'(ma.err));
        chk("a.timeout_pulse", 32'(a_tmo), 32'(ma.tmo));
        chk("b.state", 32'(b_state), 32'(mb.st));
        chk("b.global_reset", 32'(b_grst), 32'(mb.st != 0));
        chk("b.random_init", 32'(b_rinit), 32'(mb.st == 1));
        chk("b.init_memory", 32'(b_imem), 32'(mb.st == 2));
        chk("b.load_memory", 32'(b_lmem), 32'(mb.st == 4));
        chk("b.start_transaction", 32'(b_stx), 32'(mb.st == 10));
        chk("b.reset_others", 32'(b_roth), 32'(mb.st != 3));
        chk("b.src_id", 32'(b_src), 32'(mb.src));
        chk("b.dst_id", 32'(b_dst), 32'(mb.dst));
        chk("b.amount", 32'(b_amt), 32'(mb.amt));
        chk("b.key", 32'(b_key), 32'(mb.key));
        chk("b.err_pulse", 32'(b_err), 32'(mb.err));
        chk("b.timeout_pulse", 32'(b_tmo), 32'(mb.tmo));
    endtask

    // Advance n clock edges; model sees the same stable inputs as the DUTs.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            ma = step(ma, 4);
            mb = step(mb, 3);
            #1;
            check_all();
        end
    endtask

    task automatic press_val(input logic [7:0] v);
        data_in = v;
        load_signal = 1'b1;
        cyc(1);
        load_signal = 1'b0;
        cyc(3);
    endtask

    task automatic boot();
        press_val(8'h00);
        cyc(5);
        done_table_init = 1'b1;
        cyc(2);
        done_table_init = 1'b0;
        finished_init = 1'b1;
        cyc(2);
        finished_init = 1'b0;
        cyc(CLR + 2);
    endtask

    task automatic enter_txn(input logic [7:0] s, input logic [7:0] d,
                             input logic [7:0] am, input logic [7:0] k);
        press_val(8'h00);
        press_val(s);
        press_val(d);
        press_val(am);
        press_val(k);
        start_signal = 1'b1;
        cyc(1);
        start_signal = 1'b0;
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        cyc(3);
        resetn = 1'b1;
        cyc(2);

        boot();
        chk("boot_idle_a", 32'(a_state), 32'd4);
        chk("boot_lmem_a", 32'(a_lmem), 32'd1);

        enter_txn(8'h01, 8'h02, 8'h10, 8'hA5);
        chk("nominal_txn_a", 32'(a_state), 32'd10);
        chk("nominal_key_a", 32'(a_key), 32'hA5);
        cyc(5);
        finished_transaction = 1'b1;
        cyc(1);
        finished_transaction = 1'b0;
        cyc(CLR + 2);

        press_val(8'h00);
        press_val(8'h03);
        press_val(8'h03);
        cyc(CLR + 3);

        press_val(8'h00);
        press_val(8'h01);
        press_val(8'h02);
        press_val(8'h00);
        cyc(CLR + 3);

        enter_txn(8'h01, 8'h02, 8'h05, 8'h07);
        cyc(TO + 4);
        cyc(CLR + 2);

        enter_txn(8'h02, 8'h00, 8'h09, 8'h33);
        cyc(TO - 1);
        finished_transaction = 1'b1;
        cyc(1);
        finished_transaction = 1'b0;
        cyc(CLR + 2);

        press_val(8'h00);
        press_val(8'h01);
        press_val(8'h02);
        cancel = 1'b1;
        cyc(1);
        cancel = 1'b0;
        chk("cancel_zero_dst_a", 32'(a_dst), 32'd0);
        cyc(CLR + 2);

        enter_txn(8'h00, 8'h01, 8'h44, 8'h55);
        cyc(3);
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        chk("reset_stx_a", 32'(a_stx), 32'd0);
        chk("reset_state_a", 32'(a_state), 32'd0);
        cyc(2);
        boot();

        load_signal = 1'b1;
        cyc(20);
        load_signal = 1'b0;
        cyc(3);
        chk("held_button_a", 32'(a_state), 32'd5);

        for (int i = 0; i < 4000; i++) begin
            resetn               = ($urandom_range(0, 799) != 0);
            cancel               = ($urandom_range(0, 59) == 0);
            start_signal         = ($urandom_range(0, 7) == 0);
            finished_transaction = ($urandom_range(0, 11) == 0);
            done_table_init      = ($urandom_range(0, 5) == 0);
            finished_init        = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) load_signal = ~load_signal;
            data_in              = 8'($urandom_range(0, 255));
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
